gray_decoder: RTL and testbench

GRAY_DECODER -- requirements
Module: gray_decoder

---
 rtl/gray_pkg.sv | 20 ++
 rtl/gray_step_check.sv | 35 +++
 rtl/gray_decoder.sv | 143 ++++++++++++++
 tb/tb_gray_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared types and constants for the Gray-code decoder family.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

  // Code width used when the instantiating design does not override it
  localparam int DEFAULT_WIDTH = 4;

  // Decoder control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gray_step_check.sv
`default_nettype none
// ============================================================================
//  Module      : gray_step_check
//  Description : Flags two Gray codes that are not exactly one bit apart.
//                A repeated code (distance 0) is also reported.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_step_check
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] prev_code,
  input  logic [WIDTH-1:0] new_code,
  output logic             not_adjacent
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] diff;
  logic [CNT_W-1:0] ones;

  // Hamming distance between the two codes
  always_comb begin
    diff = prev_code ^ new_code;
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CNT_W'(diff[i]);
    end
  end

  assign not_adjacent = (ones != CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/gray_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : gray_decoder
//  Description : Serial Gray-to-binary decoder with valid/ready handshakes.
//                Resolves one bit per clock, MSB first, and reports whether
//                each accepted code is a single-bit step from the previous one.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_err
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t state;
  state_t next_state;

  // Transaction datapath
  logic [WIDTH-1:0] code;          // Gray word under decode
  logic [IDX_W-1:0] idx;           // bit being resolved this cycle
  logic [WIDTH-1:0] partial;       // bits resolved so far
  logic             carry;         // binary bit just above idx
  logic             resolved_bit;
  logic [WIDTH-1:0] partial_next;

  // Step tracking
  logic [WIDTH-1:0] prev_code;
  logic             first_code;
  logic             err_pending;
  logic             not_adjacent;

  logic accept;
  logic last_bit;

  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (state == DECODE) && (idx == '0);

  gray_step_check #(
    .WIDTH (WIDTH)
  ) u_step_check (
    .prev_code    (prev_code),
    .new_code     (gray_in),
    .not_adjacent (not_adjacent)
  );

  // State register; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)     next_state = DECODE;
      DECODE:  if (idx == '0)    next_state = DONE;
      DONE:    if (out_ready)    next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Current bit: bin[i] = bin[i+1] ^ g[i], with the bit above the MSB taken as 0
  always_comb begin
    resolved_bit      = carry ^ code[idx];
    partial_next      = partial;
    partial_next[idx] = resolved_bit;
  end

  // Capture on acceptance, then walk the bit index down to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code    <= '0;
      idx     <= '0;
      partial <= '0;
      carry   <= 1'b0;
    end else if (accept) begin
      code    <= gray_in;
      idx     <= IDX_MSB;
      partial <= '0;
      carry   <= 1'b0;
    end else if (state == DECODE) begin
      partial <= partial_next;
      carry   <= resolved_bit;
      if (idx != '0) begin
        idx <= idx - IDX_W'(1);
      end
    end
  end

  // Adjacency against the last accepted code; the first code is never flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code   <= '0;
      first_code  <= 1'b1;
      err_pending <= 1'b0;
    end else if (accept) begin
      prev_code   <= gray_in;
      first_code  <= 1'b0;
      err_pending <= first_code ? 1'b0 : not_adjacent;
    end
  end

  // Publish the result on the edge that resolves bit 0; it then holds until replaced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      step_err <= 1'b0;
    end else if (last_bit) begin
      bin_out  <= partial_next;
      step_err <= err_pending;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_decoder
//  Description : Self-checking bench for gray_decoder (WIDTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_decoder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] gray_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] bin_out;
  logic         step_err;

  int checks = 0;
  int errors = 0;

  gray_decoder #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .step_err  (step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Behavioural model: busy for W cycles after acceptance, then done until taken
  bit           m_busy, m_done, m_first;
  int           m_cnt;
  logic [W-1:0] m_prev, m_bin, m_pend_bin;
  logic         m_err, m_pend_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_first = 1; m_cnt = 0;
      m_prev = '0; m_bin = '0; m_err = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_done = 1;
        m_bin  = m_pend_bin;
        m_err  = m_pend_err;
      end
    end else if (in_valid) begin
      m_busy     = 1;
      m_cnt      = W;
      m_pend_bin = g2b(gray_in);
      m_pend_err = m_first ? 1'b0 : ($countones(gray_in ^ m_prev) != 1);
      m_prev     = gray_in;
      m_first    = 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cyc_in_ready",  32'(in_ready),  32'(!(m_busy || m_done)));
      chk("cyc_out_valid", 32'(out_valid), 32'(m_done));
      chk("cyc_bin_out",   32'(bin_out),   32'(m_bin));
      chk("cyc_step_err",  32'(step_err),  32'(m_err));
    end
  end

  // One transaction with literal expectations; optional backpressure hold
  task automatic xact(input logic [W-1:0] g, input logic [W-1:0] exp_bin,
                      input logic exp_err, input int hold);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    gray_in  = g;
    @(negedge clk);
    in_valid = 1'b0;
    gray_in  = ~g;
    k = 1;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(W + 1));
    chk("lit_bin", 32'(bin_out), 32'(exp_bin));
    chk("lit_err", 32'(step_err), 32'(exp_err));
    if (hold > 0) begin
      in_valid = 1'b1;
      gray_in  = 4'b1111;
      repeat (hold) @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_bin",       32'(bin_out),   32'(exp_bin));
      chk("bp_err",       32'(step_err),  32'(exp_err));
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("ret_in_ready",  32'(in_ready),  32'd1);
    chk("ret_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bin",       32'(bin_out),   32'd0);
    chk("rst_err",       32'(step_err),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] bv;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    gray_in   = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_bin",       32'(bin_out),   32'd0);
    chk("reset_err",       32'(step_err),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("model_pin_0110", 32'(g2b(4'b0110)), 32'h4);

    // Basic decode, first code after reset
    xact(4'b0110, 4'b0100, 1'b0, 0);

    // Adjacent sequence, then non-adjacent and repeated codes
    pulse_reset();
    xact(4'b0000, 4'b0000, 1'b0, 0);
    xact(4'b0001, 4'b0001, 1'b0, 0);
    xact(4'b0011, 4'b0010, 1'b0, 0);
    xact(4'b0010, 4'b0011, 1'b0, 0);
    xact(4'b0111, 4'b0101, 1'b1, 0);
    xact(4'b0111, 4'b0101, 1'b1, 0);

    // All codes in Gray order (binary-to-Gray round trip), then wrap to zero
    pulse_reset();
    for (int b = 0; b < 16; b++) begin
      bv = W'(b);
      xact(bv ^ (bv >> 1), bv, 1'b0, 0);
    end
    xact(4'b0000, 4'b0000, 1'b0, 0);

    // Backpressure with in_valid held high during DONE
    xact(4'b0001, 4'b0001, 1'b0, 10);

    // Reset two cycles into DECODE aborts the transaction
    @(negedge clk);
    in_valid = 1'b1;
    gray_in  = 4'b1100;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bin",       32'(bin_out),   32'd0);
    chk("mid_rst_err",       32'(step_err),  32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    xact(4'b1111, 4'b1010, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
